// File: rtl/fetch_sequencer.sv
// Program-counter sequencer with a small prefetch FIFO between the
// combinational instruction memory and the decode handshake.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 32,
    parameter int          DEPTH      = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fetch_en,
    input  logic                     branch_valid,
    input  logic [31:0]              branch_target,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_rdata,
    output logic                     instr_valid,
    output logic [31:0]              instr_data,
    output logic [31:0]              instr_pc,
    input  logic                     instr_ready,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int              PW         = $clog2(DEPTH);
    localparam int              CW         = PW + 1;
    localparam logic [31:0]     PC_MASK    = 32'(IMEM_WORDS * 4 - 1);
    localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FULL = 2'd2;

    logic [31:0]   pc;
    logic [31:0]   pcInc;
    logic [31:0]   branchPc;
    logic [1:0]    state;
    logic [1:0]    stateNext;
    logic [CW-1:0] count;
    logic [CW-1:0] countNext;
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;
    logic [31:0]   dataMem [DEPTH];
    logic [31:0]   pcMem   [DEPTH];
    logic          pop;
    logic          push;

    assign pop      = instr_valid & instr_ready;
    // fetch_en gates pushes directly so the first word lands on the same
    // edge that first sees fetch_en high, giving one-cycle fetch latency.
    assign push     = fetch_en & ~branch_valid & ((count < FULL_COUNT) | pop);
    assign pcInc    = (pc + 32'd4) & PC_MASK;
    assign branchPc = branch_target & ~32'd3 & PC_MASK;

    always_comb begin
        countNext = count;
        if (branch_valid) begin
            countNext = '0;
        end else if (push && !pop) begin
            countNext = count + CW'(1);
        end else if (pop && !push) begin
            countNext = count - CW'(1);
        end
    end

    always_comb begin
        stateNext = state;
        if (!fetch_en) begin
            stateNext = IDLE;
        end else if (branch_valid) begin
            stateNext = RUN;
        end else if (countNext == FULL_COUNT && !pop) begin
            stateNext = FULL;
        end else begin
            stateNext = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc    <= RESET_PC & ~32'd3;
            state <= IDLE;
            count <= '0;
            rdPtr <= '0;
            wrPtr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dataMem[i] <= '0;
                pcMem[i]   <= '0;
            end
        end else begin
            state <= stateNext;
            count <= countNext;
            if (branch_valid) begin
                pc    <= branchPc;
                rdPtr <= '0;
                wrPtr <= '0;
            end else begin
                // At full with a pop, the write reuses the slot being read out.
                if (push) begin
                    dataMem[wrPtr] <= imem_rdata;
                    pcMem[wrPtr]   <= pc;
                    wrPtr          <= wrPtr + PW'(1);
                    pc             <= pcInc;
                end
                if (pop) begin
                    rdPtr <= rdPtr + PW'(1);
                end
            end
        end
    end

    assign imem_addr   = {2'b00, pc[31:2]};
    assign instr_valid = (count != '0);
    assign instr_data  = instr_valid ? dataMem[rdPtr] : 32'd0;
    assign instr_pc    = instr_valid ? pcMem[rdPtr] : 32'd0;
    assign fifo_count  = count;

    assert property (@(posedge clk) disable iff (!rst_n) count <= FULL_COUNT);
    assert property (@(posedge clk) disable iff (!rst_n) pop |-> (count != '0));

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a queue model of the prefetch buffer
// is advanced every clock and the DUT head is compared against it.
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          IMEM_WORDS = 32;
    localparam int          DEPTH      = 2;
    localparam logic [31:0] MASK       = 32'(IMEM_WORDS * 4 - 1);

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic [1:0]  fifo_count;

    logic [31:0] tbMem [IMEM_WORDS];
    logic [63:0] sbQ [$];
    logic [31:0] modelPc;
    int          total;
    int          bad;

    fetch_sequencer #(
        .RESET_PC  (RESET_PC),
        .IMEM_WORDS(IMEM_WORDS),
        .DEPTH     (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_en     (fetch_en),
        .branch_valid (branch_valid),
        .branch_target(branch_target),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr_data   (instr_data),
        .instr_pc     (instr_pc),
        .instr_ready  (instr_ready),
        .fifo_count   (fifo_count)
    );

    assign imem_rdata = tbMem[imem_addr[4:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; the queue model follows the behavioural rules.
    task automatic tick();
        logic mPop;
        logic mPush;
        mPop  = instr_ready && (sbQ.size() != 0);
        mPush = fetch_en && !branch_valid && ((sbQ.size() < DEPTH) || mPop);
        @(posedge clk);
        if (!rst_n) begin
            sbQ.delete();
            modelPc = RESET_PC & ~32'd3;
        end else if (branch_valid) begin
            sbQ.delete();
            modelPc = branch_target & ~32'd3 & MASK;
        end else begin
            if (mPop) void'(sbQ.pop_front());
            if (mPush) begin
                sbQ.push_back({modelPc, tbMem[modelPc[6:2]]});
                modelPc = (modelPc + 32'd4) & MASK;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fetch_en = 1'b0; branch_valid = 1'b0;
        branch_target = 32'd0; instr_ready = 1'b0;
        tick(); tick();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", instr_valid); end
        total++; if (instr_data !== 32'd0) begin bad++; $display("FAIL reset_data got=%h want=0", instr_data); end
        total++; if (instr_pc !== 32'd0) begin bad++; $display("FAIL reset_pc got=%h want=0", instr_pc); end
        total++; if (fifo_count !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
        total++; if (imem_addr !== 32'd0) begin bad++; $display("FAIL reset_addr got=%h want=0", imem_addr); end
        total++; if (dut.state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", dut.state); end
    endtask

    task automatic test_stream();
        logic [63:0] exp;
        rst_n = 1'b1; fetch_en = 1'b1; instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp = (sbQ.size() != 0) ? sbQ[0] : 64'hDEAD_BEEF_DEAD_BEEF;
            total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%b want=1", i, instr_valid); end
            total++; if (instr_pc !== 32'(i * 4)) begin bad++; $display("FAIL stream_pc[%0d] got=%h want=%h", i, instr_pc, 32'(i * 4)); end
            total++; if (instr_data !== 32'hA000_0000 + 32'(i)) begin bad++; $display("FAIL stream_data[%0d] got=%h want=%h", i, instr_data, 32'hA000_0000 + 32'(i)); end
            total++; if ({instr_pc, instr_data} !== exp) begin bad++; $display("FAIL stream_sb[%0d] got=%h want=%h", i, {instr_pc, instr_data}, exp); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] addrHold;
        logic [63:0] exp;
        addrHold = 32'd0;
        instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 1) addrHold = imem_addr;
        end
        total++; if (fifo_count !== 2'd2) begin bad++; $display("FAIL bp_count got=%0d want=2", fifo_count); end
        total++; if (imem_addr !== 32'd9 || imem_addr !== addrHold) begin bad++; $display("FAIL bp_addr got=%h want=%h", imem_addr, 32'd9); end
        total++; if (dut.state !== 2'd2) begin bad++; $display("FAIL bp_state got=%0d want=2", dut.state); end
        total++; if (instr_pc !== 32'h1C) begin bad++; $display("FAIL bp_head got=%h want=1c", instr_pc); end
        instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp = (sbQ.size() != 0) ? sbQ[0] : 64'hDEAD_BEEF_DEAD_BEEF;
            total++; if (instr_pc !== 32'h20 + 32'(i * 4)) begin bad++; $display("FAIL bp_order[%0d] got=%h want=%h", i, instr_pc, 32'h20 + 32'(i * 4)); end
            total++; if (instr_valid !== 1'b1 || {instr_pc, instr_data} !== exp) begin bad++; $display("FAIL bp_sb[%0d] got=%h want=%h", i, {instr_pc, instr_data}, exp); end
        end
    endtask

    task automatic test_branch();
        logic [63:0] exp;
        branch_valid = 1'b1; branch_target = 32'h1E;
        tick();
        branch_valid = 1'b0;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL br_flush_valid got=%b want=0", instr_valid); end
        total++; if (fifo_count !== 2'd0) begin bad++; $display("FAIL br_flush_count got=%0d want=0", fifo_count); end
        total++; if (instr_data !== 32'd0) begin bad++; $display("FAIL br_flush_data got=%h want=0", instr_data); end
        tick();
        exp = (sbQ.size() != 0) ? sbQ[0] : 64'hDEAD_BEEF_DEAD_BEEF;
        total++; if (instr_pc !== 32'h1C) begin bad++; $display("FAIL br_pc got=%h want=1c", instr_pc); end
        total++; if (instr_data !== 32'hA000_0007) begin bad++; $display("FAIL br_data got=%h want=a0000007", instr_data); end
        total++; if (instr_valid !== 1'b1 || {instr_pc, instr_data} !== exp) begin bad++; $display("FAIL br_sb got=%h want=%h", {instr_pc, instr_data}, exp); end
    endtask

    task automatic test_wrap();
        logic [31:0] seq [4];
        logic [63:0] exp;
        seq[0] = 32'h78; seq[1] = 32'h7C; seq[2] = 32'h00; seq[3] = 32'h04;
        branch_valid = 1'b1; branch_target = 32'h78;
        tick();
        branch_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp = (sbQ.size() != 0) ? sbQ[0] : 64'hDEAD_BEEF_DEAD_BEEF;
            total++; if (instr_pc !== seq[i]) begin bad++; $display("FAIL wrap_pc[%0d] got=%h want=%h", i, instr_pc, seq[i]); end
            total++; if (instr_valid !== 1'b1 || {instr_pc, instr_data} !== exp) begin bad++; $display("FAIL wrap_sb[%0d] got=%h want=%h", i, {instr_pc, instr_data}, exp); end
        end
        branch_valid = 1'b1; branch_target = 32'h84;
        tick();
        branch_valid = 1'b0;
        tick();
        total++; if (instr_pc !== 32'h04) begin bad++; $display("FAIL wrap_far_pc got=%h want=4", instr_pc); end
        total++; if (instr_data !== 32'hA000_0001) begin bad++; $display("FAIL wrap_far_data got=%h want=a0000001", instr_data); end
    endtask

    task automatic test_drain();
        logic [31:0] addrHold;
        logic [63:0] exp;
        int          delivered;
        instr_ready = 1'b0;
        tick(); tick();
        total++; if (fifo_count !== 2'd2) begin bad++; $display("FAIL drain_fill got=%0d want=2", fifo_count); end
        fetch_en = 1'b0; instr_ready = 1'b1;
        addrHold = imem_addr;
        delivered = 0;
        for (int i = 0; i < 4; i++) begin
            if (instr_valid === 1'b1) begin
                delivered++;
                exp = (sbQ.size() != 0) ? sbQ[0] : 64'hDEAD_BEEF_DEAD_BEEF;
                total++; if ({instr_pc, instr_data} !== exp) begin bad++; $display("FAIL drain_sb[%0d] got=%h want=%h", i, {instr_pc, instr_data}, exp); end
            end
            tick();
        end
        total++; if (delivered != 2) begin bad++; $display("FAIL drain_delivered got=%0d want=2", delivered); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b want=0", instr_valid); end
        total++; if (imem_addr !== addrHold) begin bad++; $display("FAIL drain_addr got=%h want=%h", imem_addr, addrHold); end
        total++; if (dut.state !== 2'd0) begin bad++; $display("FAIL drain_state got=%0d want=0", dut.state); end
    endtask

    task automatic test_branch_idle();
        branch_valid = 1'b1; branch_target = 32'h41;
        tick();
        branch_valid = 1'b0;
        tick();
        total++; if (imem_addr !== 32'h10) begin bad++; $display("FAIL idle_br_addr got=%h want=10", imem_addr); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL idle_br_valid got=%b want=0", instr_valid); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp;
        fetch_en = 1'b1; instr_ready = 1'b1;
        tick(); tick();
        branch_valid = 1'b1; branch_target = 32'h40;
        tick();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL b2b_first got=%b want=0", instr_valid); end
        branch_target = 32'h20;
        tick();
        branch_valid = 1'b0;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL b2b_second got=%b want=0", instr_valid); end
        tick();
        exp = (sbQ.size() != 0) ? sbQ[0] : 64'hDEAD_BEEF_DEAD_BEEF;
        total++; if (instr_pc !== 32'h20 || instr_data !== 32'hA000_0008) begin bad++; $display("FAIL b2b_head got=%h/%h want=20/a0000008", instr_pc, instr_data); end
        total++; if ({instr_pc, instr_data} !== exp) begin bad++; $display("FAIL b2b_sb got=%h want=%h", {instr_pc, instr_data}, exp); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] exp;
        instr_ready = 1'b0;
        tick(); tick(); tick();
        total++; if (fifo_count !== 2'd2) begin bad++; $display("FAIL rmid_fill got=%0d want=2", fifo_count); end
        rst_n = 1'b0;
        tick();
        total++; if (instr_valid !== 1'b0 || instr_data !== 32'd0 || instr_pc !== 32'd0) begin bad++; $display("FAIL rmid_outputs got=%b/%h/%h want=0/0/0", instr_valid, instr_data, instr_pc); end
        total++; if (fifo_count !== 2'd0 || imem_addr !== 32'd0) begin bad++; $display("FAIL rmid_count_addr got=%0d/%h want=0/0", fifo_count, imem_addr); end
        rst_n = 1'b1; instr_ready = 1'b1;
        tick();
        exp = (sbQ.size() != 0) ? sbQ[0] : 64'hDEAD_BEEF_DEAD_BEEF;
        total++; if (instr_pc !== 32'd0 || instr_data !== 32'hA000_0000) begin bad++; $display("FAIL rmid_refetch got=%h/%h want=0/a0000000", instr_pc, instr_data); end
        total++; if (instr_valid !== 1'b1 || {instr_pc, instr_data} !== exp) begin bad++; $display("FAIL rmid_sb got=%h want=%h", {instr_pc, instr_data}, exp); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        modelPc = RESET_PC;
        for (int i = 0; i < IMEM_WORDS; i++) tbMem[i] = 32'hA000_0000 + 32'(i);
        test_reset();
        test_stream();
        test_backpressure();
        test_branch();
        test_wrap();
        test_drain();
        test_branch_idle();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
